// File: rtl/seq_stage_ctrl.sv
// Multi-cycle stage sequencer for the Y86-64 datapath.
// Steps one instruction through F/D/E/M/W/P, skipping M and W when the instruction class does not use them.
`timescale 1ns/1ps

module seq_stage_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       icode_i,
    input  logic             instr_valid_i,
    input  logic             imem_error_i,
    input  logic             mem_ready_i,
    input  logic             dmem_error_i,
    output logic             fetch_en_o,
    output logic             decode_en_o,
    output logic             execute_en_o,
    output logic             memory_en_o,
    output logic             writeback_en_o,
    output logic             pc_we_o,
    output logic [2:0]       state_o,
    output logic [2:0]       stat_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_PCUPD     = 3'd6,
        ST_HALTED    = 3'd7
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_nextState;
    logic [2:0]         r_stat;
    logic [2:0]         w_nextStat;
    logic [3:0]         r_icode;
    logic [WAIT_W-1:0]  r_wait;
    logic [CNT_W-1:0]   r_instrCnt;
    logic [CNT_W-1:0]   r_cycleCnt;
    logic               w_needMem;
    logic               w_needWb;
    logic               w_active;
    logic               w_timeout;

    // Stage routing depends on the icode latched at the end of FETCH, not the live fetch bus.
    assign w_needMem = r_icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    assign w_needWb  = r_icode inside {4'h2, 4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB};
    assign w_active  = (r_state != ST_IDLE) && (r_state != ST_HALTED);
    assign w_timeout = (r_wait == WAIT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_stat  <= STAT_AOK;
        end else begin
            r_state <= w_nextState;
            r_stat  <= w_nextStat;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextStat  = r_stat;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_nextState = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_error_i) begin
                    w_nextState = ST_HALTED;
                    w_nextStat  = STAT_ADR;
                end else if (!instr_valid_i) begin
                    w_nextState = ST_HALTED;
                    w_nextStat  = STAT_INS;
                end else if (icode_i == 4'h0) begin
                    w_nextState = ST_HALTED;
                    w_nextStat  = STAT_HLT;
                end else begin
                    w_nextState = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_nextState = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (w_needMem) begin
                    w_nextState = ST_MEMORY;
                end else if (w_needWb) begin
                    w_nextState = ST_WRITEBACK;
                end else begin
                    w_nextState = ST_PCUPD;
                end
            end
            ST_MEMORY: begin
                // A ready on the final allowed cycle takes precedence over the timeout.
                if (mem_ready_i) begin
                    if (dmem_error_i) begin
                        w_nextState = ST_HALTED;
                        w_nextStat  = STAT_ADR;
                    end else if (w_needWb) begin
                        w_nextState = ST_WRITEBACK;
                    end else begin
                        w_nextState = ST_PCUPD;
                    end
                end else if (w_timeout) begin
                    w_nextState = ST_HALTED;
                    w_nextStat  = STAT_ADR;
                end
            end
            ST_WRITEBACK: begin
                w_nextState = ST_PCUPD;
            end
            ST_PCUPD: begin
                w_nextState = ST_FETCH;
            end
            default: begin
                w_nextState = ST_HALTED;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_icode <= 4'h0;
        end else if ((r_state == ST_FETCH) && (w_nextState == ST_DECODE)) begin
            r_icode <= icode_i;
        end
    end

    // Cleared whenever outside MEMORY so every memory access starts counting from zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wait <= '0;
        end else if (r_state == ST_MEMORY) begin
            r_wait <= r_wait + WAIT_W'(1);
        end else begin
            r_wait <= '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cycleCnt <= '0;
            r_instrCnt <= '0;
        end else begin
            if (w_active) begin
                r_cycleCnt <= r_cycleCnt + CNT_W'(1);
            end
            if (r_state == ST_PCUPD) begin
                r_instrCnt <= r_instrCnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        fetch_en_o     = 1'b0;
        decode_en_o    = 1'b0;
        execute_en_o   = 1'b0;
        memory_en_o    = 1'b0;
        writeback_en_o = 1'b0;
        pc_we_o        = 1'b0;
        case (r_state)
            ST_FETCH:     fetch_en_o     = 1'b1;
            ST_DECODE:    decode_en_o    = 1'b1;
            ST_EXECUTE:   execute_en_o   = 1'b1;
            ST_MEMORY:    memory_en_o    = 1'b1;
            ST_WRITEBACK: writeback_en_o = 1'b1;
            ST_PCUPD:     pc_we_o        = 1'b1;
            default: ;
        endcase
    end

    assign state_o     = r_state;
    assign stat_o      = r_stat;
    assign busy_o      = w_active;
    assign instr_cnt_o = r_instrCnt;
    assign cycle_cnt_o = r_cycleCnt;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Testbench for seq_stage_ctrl: directed vector table, hand-written corner sequences,
// and a random instruction stream checked against a stage-list model of the sequencer.
`timescale 1ns/1ps

module tb_seq_stage_ctrl;

    localparam int CNT_W       = 5;
    localparam int MEM_TIMEOUT = 15;

    logic             clk;
    logic             rst;
    logic             start;
    logic [3:0]       icode;
    logic             instrValid;
    logic             imemError;
    logic             memReady;
    logic             dmemError;
    logic             fetchEn;
    logic             decodeEn;
    logic             executeEn;
    logic             memoryEn;
    logic             writebackEn;
    logic             pcWe;
    logic [2:0]       state;
    logic [2:0]       stat;
    logic             busy;
    logic [CNT_W-1:0] instrCnt;
    logic [CNT_W-1:0] cycleCnt;

    int testsRun;
    int testsFailed;
    int mInstr;
    int mCycle;
    int mStat;
    int expQ[$];

    typedef struct {
        logic [3:0] ic;
        bit         v;
        bit         e;
        int         readyAt;
        bit         de;
        int         expStat;
        int         expInstr;
        int         expCycles;
    } vec_t;

    vec_t vecs[$];

    seq_stage_ctrl #(
        .CNT_W(CNT_W),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .start_i(start),
        .icode_i(icode),
        .instr_valid_i(instrValid),
        .imem_error_i(imemError),
        .mem_ready_i(memReady),
        .dmem_error_i(dmemError),
        .fetch_en_o(fetchEn),
        .decode_en_o(decodeEn),
        .execute_en_o(executeEn),
        .memory_en_o(memoryEn),
        .writeback_en_o(writebackEn),
        .pc_we_o(pcWe),
        .state_o(state),
        .stat_o(stat),
        .busy_o(busy),
        .instr_cnt_o(instrCnt),
        .cycle_cnt_o(cycleCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic checkStage(input int expState);
        logic [5:0] actEn;
        logic [5:0] expEn;
        actEn = {fetchEn, decodeEn, executeEn, memoryEn, writebackEn, pcWe};
        for (int i = 1; i <= 6; i++) expEn[6-i] = (expState == i);
        checkOutput("state", 32'(state), 32'(expState));
        checkOutput("enables", 32'(actEn), 32'(expEn));
        checkOutput("busy", 32'(busy), 32'((expState != 0) && (expState != 7)));
        checkOutput("stat", 32'(stat), 32'(mStat));
        checkOutput("instrCnt", 32'(instrCnt), 32'(mInstr % (1 << CNT_W)));
        checkOutput("cycleCnt", 32'(cycleCnt), 32'(mCycle % (1 << CNT_W)));
    endtask

    // Reference model: list of stages one instruction visits, starting at FETCH.
    task automatic buildExpected(input logic [3:0] ic, input bit v, input bit e, input int readyAt,
                                 input bit de, output int haltStat);
        bit needMem;
        bit needWb;
        int n;
        expQ.delete();
        expQ.push_back(1);
        haltStat = 1;
        if (e)          begin expQ.push_back(7); haltStat = 3; return; end
        if (!v)         begin expQ.push_back(7); haltStat = 4; return; end
        if (ic == 4'h0) begin expQ.push_back(7); haltStat = 2; return; end
        expQ.push_back(2);
        expQ.push_back(3);
        needMem = ic inside {4, 5, 8, 9, 10, 11};
        needWb  = ic inside {2, 3, 5, 6, 8, 9, 10, 11};
        if (needMem) begin
            n = (readyAt >= 1 && readyAt <= MEM_TIMEOUT) ? readyAt : MEM_TIMEOUT;
            for (int i = 0; i < n; i++) expQ.push_back(4);
            if (n != readyAt || de) begin
                expQ.push_back(7);
                haltStat = 3;
                return;
            end
        end
        if (needWb) expQ.push_back(5);
        expQ.push_back(6);
    endtask

    task automatic applyStimulus(input int st, input logic [3:0] ic, input bit v, input bit e,
                                 input bit rdy, input bit de);
        start = 1'($urandom);
        if (st == 1) begin
            icode      = ic;
            instrValid = v;
            imemError  = e;
        end else begin
            icode      = 4'($urandom);
            instrValid = 1'($urandom);
            imemError  = 1'($urandom);
        end
        if (st == 4) begin
            memReady  = rdy;
            dmemError = rdy ? de : 1'($urandom);
        end else begin
            memReady  = 1'($urandom);
            dmemError = 1'($urandom);
        end
    endtask

    task automatic runInstr(input logic [3:0] ic, input bit v, input bit e, input int readyAt,
                            input bit de, output bit halted);
        int hs;
        int memCycle;
        int st;
        buildExpected(ic, v, e, readyAt, de, hs);
        halted   = (hs != 1);
        memCycle = 0;
        for (int k = 0; k < expQ.size(); k++) begin
            st = expQ[k];
            if (st == 7) mStat = hs;
            checkStage(st);
            if (st == 7) break;
            if (st == 4) memCycle++;
            applyStimulus(st, ic, v, e, (st == 4) && (memCycle == readyAt), de);
            mCycle++;
            if (st == 6) mInstr++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        rst        = 1'b1;
        start      = 1'b0;
        icode      = 4'h0;
        instrValid = 1'b0;
        imemError  = 1'b0;
        memReady   = 1'b0;
        dmemError  = 1'b0;
        #2;
        mInstr = 0;
        mCycle = 0;
        mStat  = 1;
        checkStage(0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkStage(0);
    endtask

    task automatic startRun();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic holdHalted();
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            checkStage(7);
        end
    endtask

    initial begin
        bit halted;
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;

        //           ic     v  e  rdy de stat instr cycles
        vecs.push_back('{4'h1, 1, 0, 0,  0, 1, 1, 4});
        vecs.push_back('{4'h3, 1, 0, 0,  0, 1, 1, 5});
        vecs.push_back('{4'h5, 1, 0, 3,  0, 1, 1, 8});
        vecs.push_back('{4'h0, 1, 0, 0,  0, 2, 0, 1});
        vecs.push_back('{4'h2, 0, 1, 0,  0, 3, 0, 1});
        vecs.push_back('{4'h2, 0, 0, 0,  0, 4, 0, 1});
        vecs.push_back('{4'h3, 1, 1, 0,  0, 3, 0, 1});
        vecs.push_back('{4'h4, 1, 0, 0,  0, 3, 0, 18});
        vecs.push_back('{4'h4, 1, 0, 15, 0, 1, 1, 19});
        vecs.push_back('{4'h8, 1, 0, 1,  1, 3, 0, 4});
        vecs.push_back('{4'h7, 1, 0, 0,  0, 1, 1, 4});
        vecs.push_back('{4'h6, 1, 0, 0,  0, 1, 1, 5});
        vecs.push_back('{4'h4, 1, 0, 1,  0, 1, 1, 5});
        vecs.push_back('{4'hB, 1, 0, 2,  0, 1, 1, 7});
        vecs.push_back('{4'hC, 1, 0, 0,  0, 1, 1, 4});

        for (int i = 0; i < vecs.size(); i++) begin
            doReset();
            startRun();
            runInstr(vecs[i].ic, vecs[i].v, vecs[i].e, vecs[i].readyAt, vecs[i].de, halted);
            checkOutput("tbl stat", 32'(stat), 32'(vecs[i].expStat));
            checkOutput("tbl instrCnt", 32'(instrCnt), 32'(vecs[i].expInstr));
            checkOutput("tbl cycleCnt", 32'(cycleCnt), 32'(vecs[i].expCycles));
            checkOutput("tbl state", 32'(state), (vecs[i].expStat == 1) ? 32'd1 : 32'd7);
            if (halted) holdHalted();
        end

        // Back-to-back nop, irmovq, mrmovq (ready on 3rd memory cycle).
        doReset();
        startRun();
        runInstr(4'h1, 1, 0, 0, 0, halted);
        runInstr(4'h3, 1, 0, 0, 0, halted);
        runInstr(4'h5, 1, 0, 3, 0, halted);
        checkOutput("seq instrCnt", 32'(instrCnt), 32'd3);
        checkOutput("seq cycleCnt", 32'(cycleCnt), 32'd17);
        checkOutput("seq state", 32'(state), 32'd1);

        // Asynchronous reset in the middle of a memory wait.
        doReset();
        startRun();
        icode      = 4'h5;
        instrValid = 1'b1;
        imemError  = 1'b0;
        memReady   = 1'b0;
        dmemError  = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        checkOutput("midmem state", 32'(state), 32'd4);
        checkOutput("midmem memEn", 32'(memoryEn), 32'd1);
        rst = 1'b1;
        #1;
        mInstr = 0;
        mCycle = 0;
        mStat  = 1;
        checkStage(0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkStage(0);

        // Random instruction stream; restarts after each halt.
        doReset();
        startRun();
        for (int n = 0; n < 200; n++) begin
            logic [3:0] ic;
            bit         v;
            bit         e;
            bit         de;
            int         ra;
            int         r;
            r  = $urandom_range(0, 99);
            ic = 4'($urandom_range(1, 11));
            v  = 1'b1;
            e  = 1'b0;
            de = 1'b0;
            ra = $urandom_range(1, 4);
            if (r < 3)       ic = 4'h0;
            else if (r < 5)  v  = 1'b0;
            else if (r < 7)  e  = 1'b1;
            else if (r < 10) ra = MEM_TIMEOUT;
            else if (r < 12) ra = 0;
            else if (r < 15) de = 1'b1;
            else if (r >= 95) ic = 4'($urandom_range(12, 15));
            runInstr(ic, v, e, ra, de, halted);
            if (halted) begin
                holdHalted();
                doReset();
                startRun();
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
